// File: rtl/noc_axi4_bridge_pkg.sv
// Shared types and sizing for the AXI4 bridge response path.
// Header/data widths come from the MSG_HEADER_WIDTH / AXI4_DATA_WIDTH macros when the build provides them.
`ifndef MSG_HEADER_WIDTH
`define MSG_HEADER_WIDTH 192
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif

package noc_axi4_bridge_pkg;
    typedef enum logic {RESP_RD = 1'b0, RESP_WR = 1'b1} resp_src_e;

    localparam int RESP_FIFO_DEPTH = 4;
    localparam int RESP_HDR_W      = `MSG_HEADER_WIDTH;
    localparam int RESP_DATA_W     = `AXI4_DATA_WIDTH;
    localparam int RESP_ENTRY_W    = RESP_HDR_W + RESP_DATA_W;
endpackage

// File: rtl/noc_axi4_bridge_resp_fifo.sv
// Small power-of-two FIFO that holds merged {header, data} response entries.
// Pointers wrap naturally at DEPTH; push and pop in the same cycle leave the count unchanged.
module noc_axi4_bridge_resp_fifo
    import noc_axi4_bridge_pkg::*;
#(
    parameter int DEPTH = RESP_FIFO_DEPTH,
    parameter int W     = RESP_ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push_en;
    logic          w_pop_en;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_pop_en  = i_pop && !o_empty;
    assign w_push_en = i_push && (!o_full || w_pop_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_en) r_wptr <= r_wptr + 1'b1;
            if (w_pop_en)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives entirely in r_count.
    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wptr] <= i_push_data;
    end
endmodule

// File: rtl/noc_axi4_bridge_resp_arb.sv
// Round-robin merge of AXI read/write responses into one stream for the response serializer.
// NOC_AXI4_BRIDGE_RESP_FIFO_EN selects a RESP_FIFO_DEPTH FIFO; otherwise a single output register.
module noc_axi4_bridge_resp_arb
    import noc_axi4_bridge_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RESP_HDR_W-1:0]  rd_header_in,
    input  logic [RESP_DATA_W-1:0] rd_data_in,
    input  logic                   rd_val,
    output logic                   rd_rdy,
    input  logic [RESP_HDR_W-1:0]  wr_header_in,
    input  logic                   wr_val,
    output logic                   wr_rdy,
    output logic [RESP_HDR_W-1:0]  header_out,
    output logic [RESP_DATA_W-1:0] data_out,
    output logic                   out_val,
    input  logic                   out_rdy
);
    resp_src_e                r_last_grant;
    logic                     w_grant_rd;
    logic                     w_grant_wr;
    logic                     w_room;
    logic                     w_push;
    logic                     w_pop;
    logic [RESP_ENTRY_W-1:0]  w_push_entry;
    logic [RESP_ENTRY_W-1:0]  w_head;

    assign w_grant_rd   = rd_val && (!wr_val || (r_last_grant == RESP_WR));
    assign w_grant_wr   = wr_val && !w_grant_rd;
    // rst_n gating keeps both ready lines low during reset even though storage reads as empty.
    assign rd_rdy       = rst_n && w_grant_rd && w_room;
    assign wr_rdy       = rst_n && w_grant_wr && w_room;
    assign w_push       = (rd_val && rd_rdy) || (wr_val && wr_rdy);
    assign w_pop        = out_val && out_rdy;
    assign w_push_entry = rd_rdy ? {rd_header_in, rd_data_in}
                                 : {wr_header_in, {RESP_DATA_W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_last_grant <= RESP_WR;
        else if (w_push) r_last_grant <= rd_rdy ? RESP_RD : RESP_WR;
    end

`ifdef NOC_AXI4_BRIDGE_RESP_FIFO_EN
    localparam logic [$clog2(RESP_FIFO_DEPTH):0] FULL_CNT = RESP_FIFO_DEPTH[$clog2(RESP_FIFO_DEPTH):0];

    logic                                w_full;
    logic                                w_empty;
    logic [$clog2(RESP_FIFO_DEPTH):0]    w_count;

    noc_axi4_bridge_resp_fifo #(
        .DEPTH (RESP_FIFO_DEPTH),
        .W     (RESP_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign out_val = !w_empty;
    assign w_room  = (w_count < FULL_CNT) || w_pop;

    a_full_count: assert property (@(posedge clk) disable iff (!rst_n)
                                   w_full == (w_count == FULL_CNT));
`else
    logic                    r_out_val;
    logic [RESP_ENTRY_W-1:0] r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_val <= 1'b0;
        else        r_out_val <= w_push || (r_out_val && !w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_entry <= w_push_entry;
    end

    assign out_val = r_out_val;
    assign w_head  = r_entry;
    assign w_room  = !r_out_val || w_pop;
`endif

    assign header_out = w_head[RESP_ENTRY_W-1 -: RESP_HDR_W];
    assign data_out   = w_head[RESP_DATA_W-1:0];
endmodule

// File: tb/tb_noc_axi4_bridge_resp_arb.sv
// Randomized bench for noc_axi4_bridge_resp_arb against a queue-based response model.
// Storage capacity expectation follows NOC_AXI4_BRIDGE_RESP_FIFO_EN.
module tb_noc_axi4_bridge_resp_arb;
    import noc_axi4_bridge_pkg::*;

`ifdef NOC_AXI4_BRIDGE_RESP_FIFO_EN
    localparam int CAP = RESP_FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif
    localparam int HW = RESP_HDR_W;
    localparam int DW = RESP_DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [HW-1:0] rd_header_in = '0;
    logic [DW-1:0] rd_data_in = '0;
    logic          rd_val = 1'b0;
    logic          rd_rdy;
    logic [HW-1:0] wr_header_in = '0;
    logic          wr_val = 1'b0;
    logic          wr_rdy;
    logic [HW-1:0] header_out;
    logic [DW-1:0] data_out;
    logic          out_val;
    logic          out_rdy = 1'b0;

    int vecs = 0;
    int errs = 0;

    // Model: ordered list of stored entries plus who won the last transfer.
    logic [HW+DW-1:0] m_q[$];
    logic             m_last_wr = 1'b1;
    logic             e_val, e_rrdy, e_wrdy;
    logic [HW-1:0]    e_hdr;
    logic [DW-1:0]    e_data;

    noc_axi4_bridge_resp_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_header_in (rd_header_in),
        .rd_data_in   (rd_data_in),
        .rd_val       (rd_val),
        .rd_rdy       (rd_rdy),
        .wr_header_in (wr_header_in),
        .wr_val       (wr_val),
        .wr_rdy       (wr_rdy),
        .header_out   (header_out),
        .data_out     (data_out),
        .out_val      (out_val),
        .out_rdy      (out_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vecs);
        $fatal(1, "watchdog");
    end

    function automatic logic [HW-1:0] rand_hdr();
        logic [HW-1:0] v = '0;
        for (int i = 0; i < HW; i += 32) v = (v << 32) | HW'($urandom);
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < DW; i += 32) v = (v << 32) | DW'($urandom);
        return v;
    endfunction

    task automatic model_expect();
        logic pick_rd, room;
        pick_rd = rd_val && (!wr_val || m_last_wr);
        room    = (m_q.size() < CAP) || (out_rdy && m_q.size() > 0);
        e_rrdy  = rst_n && pick_rd && room;
        e_wrdy  = rst_n && wr_val && !pick_rd && room;
        e_val   = m_q.size() > 0;
        if (e_val) {e_hdr, e_data} = m_q[0];
        else       {e_hdr, e_data} = '0;
    endtask

    task automatic tick();
        logic             acc_rd, acc_wr, pop;
        logic [HW+DW-1:0] ent;
        model_expect();
        acc_rd = e_rrdy;
        acc_wr = e_wrdy;
        pop    = e_val && out_rdy;
        ent    = acc_rd ? {rd_header_in, rd_data_in} : {wr_header_in, {DW{1'b0}}};
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_last_wr = 1'b1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc_rd || acc_wr) begin
                m_q.push_back(ent);
                m_last_wr = acc_wr;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_q.delete();
        m_last_wr = 1'b1;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rd_val = 1'b1; wr_val = 1'b1; out_rdy = 1'b1;
        rd_header_in = rand_hdr(); rd_data_in = rand_data(); wr_header_in = rand_hdr();
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if ({out_val, rd_rdy, wr_rdy} !== 3'b000) begin
                $display("FAIL reset_hold cyc %0d: val/rrdy/wrdy=%b expected 000", i, {out_val, rd_rdy, wr_rdy});
                errs++;
            end
            tick();
        end
        rst_n = 1'b1;
        #1;
        model_expect();
        vecs++;
        if ({out_val, rd_rdy, wr_rdy} !== {e_val, e_rrdy, e_wrdy}) begin
            $display("FAIL reset_first_accept: val/rrdy/wrdy=%b expected %b", {out_val, rd_rdy, wr_rdy}, {e_val, e_rrdy, e_wrdy});
            errs++;
        end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        rd_val = 1'b1; wr_val = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd_header_in = rand_hdr(); rd_data_in = rand_data(); wr_header_in = rand_hdr();
            #1;
            model_expect();
            vecs++;
            if ({out_val, rd_rdy, wr_rdy} !== {e_val, e_rrdy, e_wrdy}) begin
                $display("FAIL tie_ctrl cyc %0d: val/rrdy/wrdy=%b expected %b", i, {out_val, rd_rdy, wr_rdy}, {e_val, e_rrdy, e_wrdy});
                errs++;
            end
            vecs++;
            if (rd_rdy !== ((i % 2) == 0)) begin
                $display("FAIL tie_alternate cyc %0d: rd_rdy=%b expected %b", i, rd_rdy, (i % 2) == 0);
                errs++;
            end
            if (e_val) begin
                vecs++;
                if ({header_out, data_out} !== {e_hdr, e_data}) begin
                    $display("FAIL tie_payload cyc %0d: hdr=%h data=%h expected hdr=%h data=%h", i, header_out, data_out, e_hdr, e_data);
                    errs++;
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [HW-1:0] hdrs [6];
        logic [DW-1:0] dats [6];
        logic [HW-1:0] held;
        int k = 0, n_acc = 0, n_emit = 0;
        for (int i = 0; i < 6; i++) begin hdrs[i] = rand_hdr(); dats[i] = rand_data(); end
        do_reset();
        rd_val = 1'b1; wr_val = 1'b0; out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_header_in = hdrs[k]; rd_data_in = dats[k];
            #1;
            model_expect();
            vecs++;
            if ({out_val, rd_rdy, wr_rdy} !== {e_val, e_rrdy, e_wrdy}) begin
                $display("FAIL bp_fill cyc %0d: val/rrdy/wrdy=%b expected %b", i, {out_val, rd_rdy, wr_rdy}, {e_val, e_rrdy, e_wrdy});
                errs++;
            end
            if (rd_rdy) n_acc++;
            if (e_rrdy) k++;
            tick();
        end
        vecs++;
        if (n_acc != CAP) begin
            $display("FAIL bp_accepted: accepted %0d expected %0d", n_acc, CAP);
            errs++;
        end
        held = header_out;
        for (int i = 0; i < 10; i++) begin
            rd_header_in = hdrs[k]; rd_data_in = dats[k];
            #1;
            vecs++;
            if ({out_val, rd_rdy, header_out} !== {1'b1, 1'b0, held}) begin
                $display("FAIL bp_stable cyc %0d: val=%b rrdy=%b hdr=%h expected val=1 rrdy=0 hdr=%h", i, out_val, rd_rdy, header_out, held);
                errs++;
            end
            tick();
        end
        out_rdy = 1'b1;
        for (int c = 0; c < 20 && !(k == 6 && m_q.size() == 0); c++) begin
            rd_val = (k < 6);
            rd_header_in = hdrs[k % 6]; rd_data_in = dats[k % 6];
            #1;
            model_expect();
            vecs++;
            if ({out_val, rd_rdy, wr_rdy} !== {e_val, e_rrdy, e_wrdy}) begin
                $display("FAIL bp_drain_ctrl cyc %0d: val/rrdy/wrdy=%b expected %b", c, {out_val, rd_rdy, wr_rdy}, {e_val, e_rrdy, e_wrdy});
                errs++;
            end
            if (e_val) begin
                vecs++;
                if ({header_out, data_out} !== {e_hdr, e_data}) begin
                    $display("FAIL bp_drain_order cyc %0d: hdr=%h expected %h", c, header_out, e_hdr);
                    errs++;
                end
            end
            if (rd_val && rd_rdy) n_acc++;
            if (out_val && out_rdy) n_emit++;
            if (e_rrdy) k++;
            tick();
        end
        rd_val = 1'b0;
        vecs++;
        if (n_acc != 6 || n_emit != 6) begin
            $display("FAIL bp_totals: accepted %0d emitted %0d expected 6 and 6", n_acc, n_emit);
            errs++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 150; i++) begin
            rd_val = ($urandom % 4) != 0;
            wr_val = ($urandom % 4) != 0;
            out_rdy = $urandom % 2;
            rd_header_in = rand_hdr(); rd_data_in = rand_data(); wr_header_in = rand_hdr();
            #1;
            model_expect();
            vecs++;
            if ({out_val, rd_rdy, wr_rdy} !== {e_val, e_rrdy, e_wrdy}) begin
                $display("FAIL rand_ctrl cyc %0d: val/rrdy/wrdy=%b expected %b", i, {out_val, rd_rdy, wr_rdy}, {e_val, e_rrdy, e_wrdy});
                errs++;
            end
            if (e_val) begin
                vecs++;
                if ({header_out, data_out} !== {e_hdr, e_data}) begin
                    $display("FAIL rand_payload cyc %0d: hdr=%h data=%h expected hdr=%h data=%h", i, header_out, data_out, e_hdr, e_data);
                    errs++;
                end
            end
            tick();
        end
        rd_val = 1'b0; wr_val = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        rd_val = 1'b1; wr_val = 1'b0; out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_header_in = rand_hdr(); rd_data_in = rand_data();
            #1;
            model_expect();
            vecs++;
            if ({out_val, rd_rdy} !== {e_val, e_rrdy}) begin
                $display("FAIL arst_fill cyc %0d: val/rrdy=%b expected %b", i, {out_val, rd_rdy}, {e_val, e_rrdy});
                errs++;
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        m_q.delete();
        m_last_wr = 1'b1;
        #1;
        vecs++;
        if ({out_val, rd_rdy, wr_rdy} !== 3'b000) begin
            $display("FAIL arst_drop: val/rrdy/wrdy=%b expected 000 before next edge", {out_val, rd_rdy, wr_rdy});
            errs++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_val = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if (out_val !== 1'b0) begin
                $display("FAIL arst_stale cyc %0d: out_val=%b expected 0", i, out_val);
                errs++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
